// File: rtl/button_conditioner.sv
// Two independent push-button channels: 2-flop synchroniser + counting debounce FSM,
// giving clean active-low levels and registered one-cycle press/release strobes.

module button_conditioner_channel #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      REL_STABLE = 2'd0,
      REL_COUNT  = 2'd1,
      PRS_STABLE = 2'd2,
      PRS_COUNT  = 2'd3
   } state_t;

   logic             sync_1;
   logic             sync_2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             db_nxt;
   logic             press_nxt;
   logic             rel_nxt;

   // Plain two-flop chain; raw is asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= REL_STABLE;
         cnt   <= '0;
         level <= 1'b1;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= db_nxt;
         press <= press_nxt;
         rel   <= rel_nxt;
      end
   end

   // Any sample agreeing with the current level while counting restarts the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = level;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
         REL_STABLE: begin
            if (!sync_2) begin
               state_nxt = REL_COUNT;
               cnt_nxt   = CNT_ONE;
            end
         end
         REL_COUNT: begin
            if (sync_2) begin
               state_nxt = REL_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRS_STABLE;
               cnt_nxt   = '0;
               db_nxt    = 1'b0;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         PRS_STABLE: begin
            if (sync_2) begin
               state_nxt = PRS_COUNT;
               cnt_nxt   = CNT_ONE;
            end
         end
         PRS_COUNT: begin
            if (!sync_2) begin
               state_nxt = PRS_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = REL_STABLE;
               cnt_nxt   = '0;
               db_nxt    = 1'b1;
               rel_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = REL_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_0_raw,
   input  logic button_1_raw,
   output logic button_0,
   output logic button_1,
   output logic press_0,
   output logic press_1,
   output logic release_0,
   output logic release_1
);

   button_conditioner_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_ch0 (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button_0_raw),
      .level (button_0),
      .press (press_0),
      .rel   (release_0)
   );

   button_conditioner_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_ch1 (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button_1_raw),
      .level (button_1),
      .press (press_1),
      .rel   (release_1)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random chatter, checked against
// a run-length debounce model.

module tb_button_conditioner;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic button_0_raw;
   logic button_1_raw;
   logic button_0;
   logic button_1;
   logic press_0;
   logic press_1;
   logic release_0;
   logic release_1;

   int checks = 0;
   int errors = 0;

   // Reference: raw samples from one and two edges ago, debounced level, and the
   // length of the current run of synchronised samples that disagree with it.
   logic h1 [2];
   logic h2 [2];
   logic m_db [2];
   int   m_run [2];
   logic m_prs [2];
   logic m_rel [2];

   button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .button_0_raw (button_0_raw),
      .button_1_raw (button_1_raw),
      .button_0     (button_0),
      .button_1     (button_1),
      .press_0      (press_0),
      .press_1      (press_1),
      .release_0    (release_0),
      .release_1    (release_1)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] exp_vec();
      return {m_db[1], m_db[0], m_prs[1], m_prs[0], m_rel[1], m_rel[0]};
   endfunction

   function automatic logic [5:0] dut_vec();
      return {button_1, button_0, press_1, press_0, release_1, release_0};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         h1[c] = 1'b1; h2[c] = 1'b1; m_db[c] = 1'b1;
         m_run[c] = 0; m_prs[c] = 1'b0; m_rel[c] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         logic r;
         r = (c == 0) ? button_0_raw : button_1_raw;
         if (!rst_n) begin
            h1[c] = 1'b1; h2[c] = 1'b1; m_db[c] = 1'b1;
            m_run[c] = 0; m_prs[c] = 1'b0; m_rel[c] = 1'b0;
         end else begin
            m_prs[c] = 1'b0;
            m_rel[c] = 1'b0;
            if (h2[c] != m_db[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == D) begin
               m_db[c]  = ~m_db[c];
               m_run[c] = 0;
               if (m_db[c]) m_rel[c] = 1'b1;
               else m_prs[c] = 1'b1;
            end
            h2[c] = h1[c];
            h1[c] = r;
         end
      end
      #1;
   endtask

   task automatic cyc(input logic r0, input logic r1);
      @(negedge clk);
      button_0_raw = r0;
      button_1_raw = r1;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++;
         if (dut_vec() !== 6'b110000) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", dut_vec(), 6'b110000);
         end
      end
      @(negedge clk);
      button_0_raw = 1'b1;
      button_1_raw = 1'b1;
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut_vec() !== 6'b110000) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", dut_vec(), 6'b110000);
         end
         cyc(1'b1, 1'b1);
      end
   endtask

   task automatic test_press_release();
      int fall_e = 0, rise_e = 0, prs_e = 0, rel_e = 0, n_prs = 0, n_rel = 0;
      for (int e = 1; e <= 16; e++) begin
         cyc(1'b1, (e <= 5) ? 1'b0 : 1'b1);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL press_release_model e=%0d: got %b want %b", e, dut_vec(), exp_vec());
         end
         if (press_1 === 1'b1) begin n_prs++; prs_e = e; end
         if (release_1 === 1'b1) begin n_rel++; rel_e = e; end
         if (fall_e == 0 && button_1 === 1'b0) fall_e = e;
         if (fall_e != 0 && rise_e == 0 && button_1 === 1'b1) rise_e = e;
      end
      checks++;
      if (fall_e != 6) begin errors++; $display("FAIL fall_edge: got %0d want 6", fall_e); end
      checks++;
      if (rise_e != 11) begin errors++; $display("FAIL rise_edge: got %0d want 11", rise_e); end
      checks++;
      if (n_prs != 1 || prs_e != 6) begin
         errors++; $display("FAIL press_1_pulse: got count %0d at %0d want 1 at 6", n_prs, prs_e);
      end
      checks++;
      if (n_rel != 1 || rel_e != 11) begin
         errors++; $display("FAIL release_1_pulse: got count %0d at %0d want 1 at 11", n_rel, rel_e);
      end
   endtask

   task automatic test_short_pulse();
      int n_prs = 0, n_low = 0;
      for (int e = 1; e <= 12; e++) begin
         cyc((e <= 3) ? 1'b0 : 1'b1, 1'b1);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL short_pulse_model e=%0d: got %b want %b", e, dut_vec(), exp_vec());
         end
         if (press_0 === 1'b1) n_prs++;
         if (button_0 !== 1'b1) n_low++;
      end
      checks++;
      if (n_prs != 0 || n_low != 0) begin
         errors++; $display("FAIL short_pulse: got %0d presses %0d low cycles want 0 0", n_prs, n_low);
      end
   endtask

   task automatic test_chatter();
      logic [6:0] pat;
      int fall_e = 0;
      pat = 7'b0000100;
      for (int e = 1; e <= 14; e++) begin
         cyc((e <= 7) ? pat[e-1] : 1'b0, 1'b1);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL chatter_model e=%0d: got %b want %b", e, dut_vec(), exp_vec());
         end
         if (fall_e == 0 && button_0 === 1'b0) fall_e = e;
      end
      checks++;
      if (fall_e != 4 + D + 1) begin
         errors++; $display("FAIL chatter_fall: got edge %0d want %0d", fall_e, 4 + D + 1);
      end
      idle(12);
   endtask

   task automatic test_both();
      int p0_e = 0, p1_e = 0;
      for (int e = 1; e <= 16; e++) begin
         cyc((e <= 6) ? 1'b0 : 1'b1, (e <= 6) ? 1'b0 : 1'b1);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL both_model e=%0d: got %b want %b", e, dut_vec(), exp_vec());
         end
         if (press_0 === 1'b1) p0_e = e;
         if (press_1 === 1'b1) p1_e = e;
         checks++;
         if (button_0 !== button_1) begin
            errors++; $display("FAIL both_levels e=%0d: got %b %b want equal", e, button_0, button_1);
         end
      end
      checks++;
      if (p0_e != 6 || p1_e != 6) begin
         errors++; $display("FAIL both_press: got edges %0d %0d want 6 6", p0_e, p1_e);
      end
   endtask

   task automatic test_reset_midcount();
      int fall_e = 0, n_prs = 0;
      idle(4);
      for (int e = 1; e <= 4; e++) cyc(1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (dut_vec() !== 6'b110000) begin
            errors++; $display("FAIL midcount_reset: got %b want %b", dut_vec(), 6'b110000);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         if (e == 1) step();
         else cyc(1'b1, 1'b0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midcount_model e=%0d: got %b want %b", e, dut_vec(), exp_vec());
         end
         if (press_1 === 1'b1) n_prs++;
         if (fall_e == 0 && button_1 === 1'b0) fall_e = e;
      end
      checks++;
      if (fall_e != 6 || n_prs != 1) begin
         errors++; $display("FAIL midcount_fall: got edge %0d presses %0d want 6 1", fall_e, n_prs);
      end
      idle(12);
   endtask

   task automatic test_random();
      logic r [2];
      int hold [2];
      for (int c = 0; c < 2; c++) begin r[c] = 1'b1; hold[c] = 0; end
      for (int i = 0; i < 500; i++) begin
         if (i == 250) rst_n = 1'b0;
         if (i == 254) rst_n = 1'b1;
         for (int c = 0; c < 2; c++) begin
            if (hold[c] == 0) begin
               r[c] = ~r[c];
               hold[c] = $urandom_range(1, 2 * D + 2);
            end
            hold[c]--;
         end
         cyc(r[0], r[1]);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_model i=%0d: got %b want %b", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      button_0_raw = 1'b1;
      button_1_raw = 1'b1;
      model_reset();
      test_reset();
      test_press_release();
      test_short_pulse();
      test_chatter();
      test_both();
      test_reset_midcount();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
